// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
//   arb_state_e : arbiter FSM state (IDLE = choosing a source, GRANT = streaming)
//   SRC_W/CNT_W : source-index and beat-counter widths for the default configuration
//   rr_pick     : rotating-priority search over up to MAX_SRC request bits
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int MAX_SRC       = 8;
  localparam int DEF_NUM_SRC   = 4;
  localparam int DEF_BURST_MAX = 8;
  localparam int SRC_W         = $clog2(DEF_NUM_SRC);
  localparam int CNT_W         = $clog2(DEF_BURST_MAX + 1);

  // Returns {found, index}: the first set bit of req[n-1:0] searching upward
  // from ptr and wrapping modulo n. The loop runs high-to-low so the closest
  // candidate to ptr is the last one written and therefore wins.
  function automatic logic [3:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [3:0] res;
    logic [2:0] i3;
    int         idx;
    res = '0;
    for (int k = MAX_SRC - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        i3  = idx[2:0];
        if (req[i3]) res = {1'b1, i3};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry registered stage for a valid/ready stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data captured when both high
//   out_valid/out_ready : downstream handshake, out_data held while out_valid && !out_ready
// Handshake rule: a beat moves when valid && ready on the same rising edge;
// valid never depends on ready, ready may depend on the downstream ready.
module stream_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // The register may be reloaded when it is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready sink among NUM_SRC sources.
//   clk, rst_n       : clock, asynchronous active-low reset
//   s_data/s_valid   : packed per-source data (source i at [i*DATA_W +: DATA_W]) and valids
//   s_ready          : per-source ready, at most one bit high (the granted source)
//   m_data/m_valid   : registered output beat, m_ready is the downstream ready
//   m_src            : index of the source that produced m_data
//   busy             : FSM state view, high while in GRANT
// Handshake rule: a beat moves when valid && ready on the same rising edge;
// valid never depends on ready, ready may depend on the downstream ready.
module rr_stream_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*DATA_W-1:0]   s_data,
  input  logic [NUM_SRC-1:0]          s_valid,
  output logic [NUM_SRC-1:0]          s_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(NUM_SRC)-1:0]  m_src,
  output logic                        busy
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int SW = DATA_W + IW;

  arb_state_e         state, state_nxt;
  logic [IW-1:0]      gnt_idx, gnt_nxt;
  logic [IW-1:0]      rr_ptr, rr_nxt, gnt_inc;
  logic [BW-1:0]      beat_cnt, cnt_nxt;
  logic [MAX_SRC-1:0] req_pad;
  logic [3:0]         pick;
  logic               load_en, gnt_valid, take, last_beat;
  logic [DATA_W-1:0]  sel_data;
  logic [SW-1:0]      slice_out;

  always_comb begin
    req_pad = '0;
    req_pad[NUM_SRC-1:0] = s_valid;
  end

  assign pick      = rr_pick(req_pad, 3'(rr_ptr), NUM_SRC);
  assign gnt_valid = s_valid[gnt_idx];
  assign gnt_inc   = (gnt_idx == IW'(NUM_SRC - 1)) ? '0 : gnt_idx + IW'(1);
  assign last_beat = (int'(beat_cnt) + 1 == BURST_MAX);
  assign take      = (state == GRANT) && gnt_valid && load_en;
  assign busy      = (state == GRANT);

  // Ready follows load_en, so it is combinational from m_ready. It is not
  // gated by the granted source's valid; a dropped valid simply moves nothing.
  always_comb begin
    s_ready = '0;
    if (state == GRANT && load_en) s_ready[gnt_idx] = 1'b1;
  end

  // Only the granted source's data ever reaches the output register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx == IW'(i)) sel_data = s_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_idx;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick[3]) begin
          state_nxt = GRANT;
          gnt_nxt   = IW'(pick[2:0]);
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!gnt_valid) begin
          // Source abandoned its burst: give the next source priority.
          state_nxt = IDLE;
          rr_nxt    = gnt_inc;
        end else if (load_en) begin
          if (last_beat) begin
            state_nxt = IDLE;
            rr_nxt    = gnt_inc;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = beat_cnt + BW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt_idx  <= gnt_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // Source index travels with the data so m_src always matches m_data.
  stream_reg_slice #(.W(SW)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (take),
    .in_ready  (load_en),
    .in_data   ({gnt_idx, sel_data}),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (slice_out)
  );

  assign {m_src, m_data} = slice_out;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
module tb_rr_stream_arbiter;
  import arb_pkg::*;

  typedef struct {
    logic [3:0] sv;
    logic       mr;
    logic       eb;
    logic [3:0] erdy;
    logic       ev;
    logic [1:0] es;
    int         etick;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic [127:0]      s_data;
  logic [3:0]        s_valid;
  logic [3:0]        s_ready;
  logic [31:0]       m_data;
  logic              m_valid;
  logic              m_ready;
  logic [SRC_W-1:0]  m_src;
  logic              busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          base;
  int          sent;
  logic        hs;
  vec_t        vt[64];
  logic [31:0] exp_q[$];

  rr_stream_arbiter #(.NUM_SRC(4), .DATA_W(32), .BURST_MAX(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_src   (m_src),
    .busy    (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (!$onehot0(s_ready)) begin
        n_bad++;
        $display("FAIL s_ready_onehot: got %b, required one-hot or zero", s_ready);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic setv(input int k, input logic [3:0] sv, input logic mr, input logic eb,
                      input logic [3:0] erdy, input logic ev, input logic [1:0] es,
                      input int etick);
    vt[k].sv = sv; vt[k].mr = mr; vt[k].eb = eb; vt[k].erdy = erdy;
    vt[k].ev = ev; vt[k].es = es; vt[k].etick = etick;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".m_valid"}, m_valid, 0);
    chk({tag, ".m_data"},  m_data,  0);
    chk({tag, ".m_src"},   m_src,   0);
    chk({tag, ".s_ready"}, s_ready, 0);
    chk({tag, ".busy"},    busy,    0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = '0;
    m_ready = 1'b0;
    s_data  = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  // driver: source i presents {i, cycle number} so every beat is traceable
  task automatic run_vecs(input int n, input string tag);
    logic [31:0] ed;
    for (int k = 0; k < n; k++) begin
      s_valid = vt[k].sv;
      m_ready = vt[k].mr;
      for (int i = 0; i < 4; i++) s_data[i*32 +: 32] = {4'(i), 28'(cyc)};
      #1;
      chk($sformatf("%s[%0d].m_valid", tag, k), m_valid, vt[k].ev);
      chk($sformatf("%s[%0d].s_ready", tag, k), s_ready, vt[k].erdy);
      chk($sformatf("%s[%0d].busy", tag, k), busy, vt[k].eb);
      if (vt[k].ev) begin
        ed = {4'(vt[k].es), 28'(vt[k].etick)};
        chk($sformatf("%s[%0d].m_src", tag, k), m_src, vt[k].es);
        chk($sformatf("%s[%0d].m_data", tag, k), m_data, ed);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = '0;
    m_ready = 1'b0;
    s_data  = '0;
    #2;
    check_reset_outputs("por");
    do_reset();

    // all four sources streaming: 8 beats each, one bubble per grant switch
    base = cyc;
    setv(0, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 0);
    for (int t = 1; t < 39; t++) begin
      int u, b, p;
      u = t - 1;
      b = (u / 9) % 4;
      p = u % 9;
      setv(t, 4'hF, 1'b1, p < 8, (p < 8) ? 4'(1 << b) : 4'h0, p >= 1, 2'(b), base + t - 1);
    end
    run_vecs(39, "all_src");

    // sole requester: 0x10..0x1F delivered as 8 beats, gap, 8 beats
    do_reset();
    sent = 0;
    exp_q.delete();
    for (int t = 0; t < 19; t++) begin
      s_valid = (sent < 16) ? 4'b0100 : 4'b0000;
      s_data  = '0;
      s_data[64 +: 32] = 32'h10 + 32'(sent);
      m_ready = 1'b1;
      #1;
      chk($sformatf("solo[%0d].m_valid", t), m_valid,
          (t >= 2 && t <= 9) || (t >= 11 && t <= 18));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL solo[%0d].extra_beat: got %0h, required no beat", t, m_data);
        end else begin
          chk($sformatf("solo[%0d].m_data", t), m_data, exp_q.pop_front());
          chk($sformatf("solo[%0d].m_src", t), m_src, 2);
        end
      end
      hs = s_valid[2] && s_ready[2];
      if (hs) exp_q.push_back(32'h10 + 32'(sent));
      @(posedge clk); #1;
      if (hs) sent++;
      cyc++;
    end
    chk("solo.beats_taken", sent, 16);
    chk("solo.beats_left", exp_q.size(), 0);

    // back-pressure for 5 cycles after two beats; burst still totals 8
    do_reset();
    base = cyc;
    setv(0, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 0);
    setv(1, 4'hF, 1'b1, 1'b1, 4'h1, 1'b0, 2'd0, 0);
    setv(2, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, base + 1);
    for (int k = 3; k < 8; k++) setv(k, 4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 2'd0, base + 2);
    setv(8, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, base + 2);
    for (int k = 9; k < 14; k++) setv(k, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, base + k - 1);
    setv(14, 4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, base + 13);
    setv(15, 4'hF, 1'b1, 1'b1, 4'h2, 1'b0, 2'd0, 0);
    run_vecs(16, "bp");

    // reset mid-burst (source 1 granted, rr_ptr past 0), then first grant is 0
    chk("rst_mid.pre_m_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
    base = cyc;
    setv(0, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 0);
    setv(1, 4'hF, 1'b1, 1'b1, 4'h1, 1'b0, 2'd0, 0);
    setv(2, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, base + 1);
    run_vecs(3, "post_rst");

    // source 1 drops after 3 beats -> next grant is 3; then 3 wraps to 0
    do_reset();
    base = cyc;
    setv(0, 4'b0010, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 0);
    setv(1, 4'b1011, 1'b1, 1'b1, 4'h2, 1'b0, 2'd0, 0);
    setv(2, 4'b1011, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, base + 1);
    setv(3, 4'b1011, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, base + 2);
    setv(4, 4'b1001, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, base + 3);
    setv(5, 4'b1001, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 0);
    for (int k = 6; k < 14; k++)
      setv(k, 4'b1001, 1'b1, 1'b1, 4'h8, k >= 7, 2'd3, base + k - 1);
    setv(14, 4'b1001, 1'b1, 1'b0, 4'h0, 1'b1, 2'd3, base + 13);
    setv(15, 4'b1001, 1'b1, 1'b1, 4'h1, 1'b0, 2'd0, 0);
    setv(16, 4'b1001, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, base + 15);
    run_vecs(17, "drop_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Shares one 32-bit valid/ready sink among NUM_SRC counter-style stream sources (tx-type generators).
- Round-robin arbitration with a per-grant burst limit, so no source can starve the others.
- Single registered output stage; sits between the source generators and the downstream consumer.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
DATA_W, 32, data width per source
BURST_MAX, 8, max beats transferred per grant before forced re-arbitration (1..255)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
s_data  input  NUM_SRC*DATA_W  source data, source i at bits [i*DATA_W +: DATA_W]
s_valid  input  NUM_SRC  per-source valid
s_ready  output  NUM_SRC  per-source ready, at most one bit high
m_data  output  DATA_W  registered output data
m_valid  output  1  registered output valid
m_ready  input  1  downstream ready
m_src  output  $clog2(NUM_SRC)  index of the source that produced m_data
busy  output  1  high while in GRANT state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, m_valid=0, m_data=0, m_src=0, s_ready=0, busy=0, rr_ptr=0, beat_cnt=0. Reset mid-burst discards the held output beat.
- Output stage: load_en = !m_valid || m_ready. A beat is accepted from source g when s_valid[g] && s_ready[g]. m_valid/m_data/m_src update on the next edge (latency 1). m_valid falls when m_ready && no new beat is accepted.
- m_data and m_src stay stable while m_valid && !m_ready.
- s_ready[g] = (state==GRANT) && (g==gnt_idx) && load_en; all other bits are 0. The s_ready path is combinational from m_ready.
- IDLE: if any s_valid, choose the first set bit searching from rr_ptr upward, with wrap modulo NUM_SRC. Register gnt_idx, clear beat_cnt, go to GRANT. If no s_valid, stay in IDLE.
- GRANT, on each accepted beat: beat_cnt increments. If beat_cnt+1 == BURST_MAX, go to IDLE with rr_ptr = gnt_idx+1 (mod NUM_SRC).
- GRANT, when s_valid[gnt_idx]==0: go to IDLE the same cycle with no transfer, and rr_ptr = gnt_idx+1. A source that drops valid ends its burst.
- GRANT, when s_valid[gnt_idx]==1 but load_en==0: hold state; beat_cnt unchanged.
- Arbitration costs one bubble cycle per grant switch (IDLE→GRANT).
- A sole requester is re-granted after its own burst limit, following the bubble cycle.
- beat_cnt width: $clog2(BURST_MAX+1). It never exceeds BURST_MAX-1 while in GRANT.
- Sources may drop valid without a handshake; the arbiter never samples data from a non-granted source.
- rr_ptr wraps from NUM_SRC-1 to 0.

Decomposition:
- Package arb_pkg:
  - state enum {IDLE, GRANT}
  - localparam SRC_W = $clog2(NUM_SRC)
  - localparam CNT_W
  - rotate-priority-pick function
- One sub-module, stream_reg_slice:
  - 1-entry output register carrying data and src id
  - ports: in_valid, in_ready, in_data, out_valid, out_ready, out_data
  - async active-low reset
- Top level holds the FSM, rr_ptr, beat_cnt and the mux.

Test Plan:
1. Reset mid-burst: rst_n low while m_valid=1 → m_valid=0, s_ready=0, busy=0 immediately. After release, the first grant goes to source 0 when all sources are valid.
2. All 4 sources valid continuously, m_ready=1, BURST_MAX=8 → m_src sequence 0×8, bubble, 1×8, bubble, 2×8, bubble, 3×8, then back to 0. m_data equals the corresponding source data each beat.
3. Only source 2 valid, its data counting 0x10..0x1F → grants 2 repeatedly. Output shows 8 beats, a 1-cycle gap, then 8 beats; no data is lost or duplicated.
4. Back-pressure: m_ready=0 for 5 cycles mid-burst → m_data and m_src are frozen and s_ready=0. beat_cnt resumes afterwards, so the burst still totals exactly 8 beats.
5. Source 1 drops s_valid after 3 beats while sources 0 and 3 are valid → grant ends after 3 beats, rr_ptr=2, and the next grant goes to source 3 (not 0).
6. Only sources 0 and 3 valid, rr_ptr at 3 → grants 3, then wraps to 0. Check s_ready is one-hot or zero every cycle (assertion).
